// File: rtl/mipi_csi2_pkt_protect_if.sv
// Byte-stream bundle for mipi_csi2_pkt_protect.
//   in_valid/in_sop/in_data/in_ready        : raw packet bytes from the sequencer
//   out_valid/out_sop/out_eop/out_data/out_ready : protected stream to the PHY
// slave  : view taken by the protect block
// master : view taken by whatever drives the raw side and sinks the output
interface mipi_csi2_pkt_protect_if;
  logic       in_valid;
  logic       in_sop;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;
  logic [7:0] out_data;
  logic       out_ready;

  modport slave (
    input  in_valid, in_sop, in_data, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_data
  );

  modport master (
    output in_valid, in_sop, in_data, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_data
  );
endinterface

// File: rtl/mipi_csi2_pkt_protect.sv
// CSI-2 packet protection stage (high-speed byte domain).
// Takes raw packets (DI, WC lo, WC hi, payload), inserts the header ECC after
// the third byte and, for long packets, appends the payload CRC (LSB first).
// Optional feature macro: MIPI_CSI2_CRC_EN. When undefined the CRC datapath is
// absent and both checksum bytes are sent as 0x00; framing/timing are unchanged.
// Ports:
//   clk_hs  : byte clock
//   resetb  : asynchronous active-low reset
//   enable  : low holds the block idle, flushes the output, stalls the input
//   bus     : in_* / out_* byte streams (slave modport)
//   err_cnt : saturating count of aborted / orphaned packets
module mipi_csi2_pkt_protect #(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_hs,
  input  logic                     resetb,
  input  logic                     enable,
  mipi_csi2_pkt_protect_if.slave   bus,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ECC, S_PAY, S_CRC0, S_CRC1} state_t;

  state_t      state;
  logic [23:0] hdr;      // {WC hi, WC lo, DI}; bytes not yet seen stay zero
  logic        hdr_hi;   // next header byte is WC hi
  logic [15:0] pay_cnt;
  logic        drop;     // orphan bytes already counted / packet discarded
  logic [15:0] crc;
  logic        adv;
  logic        in_state;
  logic        hold_sop;
  logic        err_inc;
  logic        is_long;
  logic [15:0] wc;

  function automatic logic [7:0] hdr_ecc(input logic [23:0] d);
    return {2'b00,
            ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction

  always_comb begin
    adv      = enable && (!bus.out_valid || bus.out_ready);
    in_state = (state == S_IDLE) || (state == S_HDR) || (state == S_PAY);
    // A new SOP inside a packet truncates it; the SOP byte waits until the
    // truncated packet has been closed.
    hold_sop = bus.in_valid && bus.in_sop && ((state == S_HDR) || (state == S_PAY));
    err_inc  = adv && (hold_sop ||
               ((state == S_IDLE) && bus.in_valid && !bus.in_sop && !drop));
    is_long  = |hdr[5:4];
    wc       = hdr[23:8];
  end

  assign bus.in_ready = adv && in_state && !hold_sop;

`ifdef MIPI_CSI2_CRC_EN
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk_hs or negedge resetb) begin
    if (!resetb) begin
      crc <= 16'hFFFF;
    end else if (bus.in_valid && bus.in_ready) begin
      if ((state == S_IDLE) && bus.in_sop) crc <= 16'hFFFF;
      else if (state == S_PAY)             crc <= crc_next(crc, bus.in_data);
    end
  end
`else
  assign crc = '0;
`endif

  always_ff @(posedge clk_hs or negedge resetb) begin
    if (!resetb)                          err_cnt <= '0;
    else if (err_inc && (err_cnt != '1))  err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_hs or negedge resetb) begin
    if (!resetb) begin
      state         <= S_IDLE;
      hdr           <= '0;
      hdr_hi        <= 1'b0;
      pay_cnt       <= '0;
      drop          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= 1'b0;
      bus.out_data  <= '0;
    end else if (!enable) begin
      // Remaining bytes of a packet cut off here are discarded silently.
      if (state != S_IDLE) drop <= 1'b1;
      state         <= S_IDLE;
      bus.out_valid <= 1'b0;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= 1'b0;
      bus.out_sop   <= 1'b0;
      bus.out_eop   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_sop) begin
              bus.out_valid <= 1'b1;
              bus.out_sop   <= 1'b1;
              bus.out_data  <= bus.in_data;
              hdr           <= {16'h0000, bus.in_data};
              hdr_hi        <= 1'b0;
              drop          <= 1'b0;
              state         <= S_HDR;
            end else begin
              drop <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (hold_sop) begin
            bus.out_valid <= 1'b1;
            bus.out_eop   <= 1'b1;
            bus.out_data  <= hdr_ecc(hdr);
            state         <= S_IDLE;
          end else if (bus.in_valid) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data;
            if (!hdr_hi) begin
              hdr[15:8] <= bus.in_data;
              hdr_hi    <= 1'b1;
            end else begin
              hdr[23:16] <= bus.in_data;
              state      <= S_ECC;
            end
          end
        end
        S_ECC: begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= hdr_ecc(hdr);
          if (!is_long) begin
            bus.out_eop <= 1'b1;
            state       <= S_IDLE;
          end else if (wc == 16'h0000) begin
            state <= S_CRC0;
          end else begin
            pay_cnt <= wc;
            state   <= S_PAY;
          end
        end
        S_PAY: begin
          // On truncation the low CRC byte goes out in the same cycle.
          if (hold_sop) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= crc[7:0];
            state         <= S_CRC1;
          end else if (bus.in_valid) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data;
            pay_cnt       <= pay_cnt - 16'd1;
            if (pay_cnt == 16'd1) state <= S_CRC0;
          end
        end
        S_CRC0: begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= crc[7:0];
          state         <= S_CRC1;
        end
        S_CRC1: begin
          bus.out_valid <= 1'b1;
          bus.out_eop   <= 1'b1;
          bus.out_data  <= crc[15:8];
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
